// File: rtl/fifo_tmr_pkg.sv
// Shared helpers for the TMR async FIFO pointer logic (read and write domain controllers).
// Pointer math is done on PTR_MAX-bit vectors; callers zero-extend and slice to their width.
package fifo_tmr_pkg;

    localparam int PTR_MAX = 32;

    function automatic int ptr_width(input int address_bits);
        return address_bits + 1;
    endfunction

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
        logic [PTR_MAX-1:0] bin;
        bin = gray;
        for (int i = 1; i < PTR_MAX; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

    function automatic logic [PTR_MAX-1:0] vote3(input logic [PTR_MAX-1:0] a,
                                                 input logic [PTR_MAX-1:0] b,
                                                 input logic [PTR_MAX-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
module fifo_ptr_sync #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Two-stage capture of the foreign-domain pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/fifo_read_ctrl_tmr.sv
// Read-domain controller of the TMR async FIFO: read pointer, empty flag, registered pop data.
// Define READ_PTR_TMR_EN to triplicate and vote the pointer, Gray and empty state.
module fifo_read_ctrl_tmr
    import fifo_tmr_pkg::*;
#(
    parameter int WIDTH_SIZE   = 64,
    parameter int ADDRESS_SIZE = 10
) (
    input  logic                    read_clk,
    input  logic                    read_reset_n,
    input  logic                    read_enable,
    input  logic [ADDRESS_SIZE:0]   write_ptr_gray,
    input  logic [WIDTH_SIZE-1:0]   mem_read_data,
    output logic [ADDRESS_SIZE-1:0] read_address,
    output logic [ADDRESS_SIZE:0]   read_ptr_gray,
    output logic [WIDTH_SIZE-1:0]   read_data,
    output logic                    read_valid,
    output logic                    read_empty,
    output logic                    tmr_error
);

    localparam int PW = ptr_width(ADDRESS_SIZE);

    logic [PW-1:0]         wq2_ptr_s;
    logic [PW-1:0]         voted_bin_s;
    logic [PW-1:0]         bin_next_s;
    logic [PW-1:0]         gray_next_s;
    logic [PTR_MAX-1:0]    gray_ext_s;
    logic                  voted_empty_s;
    logic                  pop_s;
    logic [WIDTH_SIZE-1:0] read_data_r;
    logic                  read_valid_r;

    fifo_ptr_sync #(.WIDTH(PW)) u_wptr_sync (
        .clk   (read_clk),
        .rst_n (read_reset_n),
        .d     (write_ptr_gray),
        .q     (wq2_ptr_s)
    );

    // Next pointer from the voted pointer; a pop while empty leaves it unchanged
    always_comb begin
        pop_s       = read_enable & ~voted_empty_s;
        bin_next_s  = voted_bin_s + {{(PW-1){1'b0}}, pop_s};
        gray_ext_s  = bin2gray({{(PTR_MAX-PW){1'b0}}, bin_next_s});
        gray_next_s = gray_ext_s[PW-1:0];
    end

`ifdef READ_PTR_TMR_EN
    logic [PW-1:0]      bin0_r, bin1_r, bin2_r;
    logic [PW-1:0]      gray0_r, gray1_r, gray2_r;
    logic               empty0_r, empty1_r, empty2_r;
    logic               tmr_error_r;
    logic [PTR_MAX-1:0] bin_vote_s;
    logic [PTR_MAX-1:0] gray_vote_s;
    logic               unused_hi_s;

    // Bitwise majority over the three copies of each pointer register
    always_comb begin
        bin_vote_s    = vote3({{(PTR_MAX-PW){1'b0}}, bin0_r},
                              {{(PTR_MAX-PW){1'b0}}, bin1_r},
                              {{(PTR_MAX-PW){1'b0}}, bin2_r});
        gray_vote_s   = vote3({{(PTR_MAX-PW){1'b0}}, gray0_r},
                              {{(PTR_MAX-PW){1'b0}}, gray1_r},
                              {{(PTR_MAX-PW){1'b0}}, gray2_r});
        voted_bin_s   = bin_vote_s[PW-1:0];
        voted_empty_s = (empty0_r & empty1_r) | (empty0_r & empty2_r) | (empty1_r & empty2_r);
    end

    assign unused_hi_s = ^{bin_vote_s[PTR_MAX-1:PW], gray_vote_s[PTR_MAX-1:PW],
                           gray_ext_s[PTR_MAX-1:PW]};

    // All copies reload from the voted next value, scrubbing a single upset in one cycle
    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            bin0_r      <= {PW{1'b0}};
            bin1_r      <= {PW{1'b0}};
            bin2_r      <= {PW{1'b0}};
            gray0_r     <= {PW{1'b0}};
            gray1_r     <= {PW{1'b0}};
            gray2_r     <= {PW{1'b0}};
            empty0_r    <= 1'b1;
            empty1_r    <= 1'b1;
            empty2_r    <= 1'b1;
            tmr_error_r <= 1'b0;
        end else begin
            bin0_r      <= bin_next_s;
            bin1_r      <= bin_next_s;
            bin2_r      <= bin_next_s;
            gray0_r     <= gray_next_s;
            gray1_r     <= gray_next_s;
            gray2_r     <= gray_next_s;
            empty0_r    <= (gray_next_s == wq2_ptr_s);
            empty1_r    <= (gray_next_s == wq2_ptr_s);
            empty2_r    <= (gray_next_s == wq2_ptr_s);
            tmr_error_r <= (bin0_r != voted_bin_s) | (bin1_r != voted_bin_s) |
                           (bin2_r != voted_bin_s);
        end
    end

    assign read_ptr_gray = gray_vote_s[PW-1:0];
    assign tmr_error     = tmr_error_r;
`else
    logic [PW-1:0] bin_r;
    logic [PW-1:0] gray_r;
    logic          empty_r;
    logic          unused_hi_s;

    assign voted_bin_s   = bin_r;
    assign voted_empty_s = empty_r;
    assign unused_hi_s   = ^gray_ext_s[PTR_MAX-1:PW];

    // Single-copy pointer, Gray pointer and empty flag
    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            bin_r   <= {PW{1'b0}};
            gray_r  <= {PW{1'b0}};
            empty_r <= 1'b1;
        end else begin
            bin_r   <= bin_next_s;
            gray_r  <= gray_next_s;
            empty_r <= (gray_next_s == wq2_ptr_s);
        end
    end

    assign read_ptr_gray = gray_r;
    assign tmr_error     = 1'b0;
`endif

    // Popped word capture; data holds between pops
    always_ff @(posedge read_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            read_data_r  <= {WIDTH_SIZE{1'b0}};
            read_valid_r <= 1'b0;
        end else begin
            read_valid_r <= pop_s;
            if (pop_s) begin
                read_data_r <= mem_read_data;
            end else begin
                read_data_r <= read_data_r;
            end
        end
    end

    assign read_address = voted_bin_s[ADDRESS_SIZE-1:0];
    assign read_data    = read_data_r;
    assign read_valid   = read_valid_r;
    assign read_empty   = voted_empty_s;

endmodule

// File: tb/tb_fifo_read_ctrl_tmr.sv
// Directed self-checking bench for fifo_read_ctrl_tmr (ADDRESS_SIZE=4, WIDTH_SIZE=8).
module tb_fifo_read_ctrl_tmr;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [AW:0]   wptr;
    logic [DW-1:0] mem;
    logic [AW-1:0] addr;
    logic [AW:0]   rgray;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rempty;
    logic          terr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          en;
        logic [DW-1:0] din;
        logic [AW-1:0] exp_addr;
        logic [AW:0]   exp_gray;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[17];

    fifo_read_ctrl_tmr #(.WIDTH_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
        .read_clk       (clk),
        .read_reset_n   (rst_n),
        .read_enable    (en),
        .write_ptr_gray (wptr),
        .mem_read_data  (mem),
        .read_address   (addr),
        .read_ptr_gray  (rgray),
        .read_data      (rdata),
        .read_valid     (rvalid),
        .read_empty     (rempty),
        .tmr_error      (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // idle padding while the new write pointer crosses, then 14 pops from address 2 to 16
        vecs[0] = '{1'b0, 8'h00, 4'd2, 5'b00011, 1'b0, 8'hB2};
        vecs[1] = '{1'b0, 8'h00, 4'd2, 5'b00011, 1'b0, 8'hB2};
        vecs[2] = '{1'b0, 8'h00, 4'd2, 5'b00011, 1'b0, 8'hB2};
        vecs[3]  = '{1'b1, 8'h10, 4'd2,  5'b00010, 1'b1, 8'h10};
        vecs[4]  = '{1'b1, 8'h11, 4'd3,  5'b00110, 1'b1, 8'h11};
        vecs[5]  = '{1'b1, 8'h12, 4'd4,  5'b00111, 1'b1, 8'h12};
        vecs[6]  = '{1'b1, 8'h13, 4'd5,  5'b00101, 1'b1, 8'h13};
        vecs[7]  = '{1'b1, 8'h14, 4'd6,  5'b00100, 1'b1, 8'h14};
        vecs[8]  = '{1'b1, 8'h15, 4'd7,  5'b01100, 1'b1, 8'h15};
        vecs[9]  = '{1'b1, 8'h16, 4'd8,  5'b01101, 1'b1, 8'h16};
        vecs[10] = '{1'b1, 8'h17, 4'd9,  5'b01111, 1'b1, 8'h17};
        vecs[11] = '{1'b1, 8'h18, 4'd10, 5'b01110, 1'b1, 8'h18};
        vecs[12] = '{1'b1, 8'h19, 4'd11, 5'b01010, 1'b1, 8'h19};
        vecs[13] = '{1'b1, 8'h1A, 4'd12, 5'b01011, 1'b1, 8'h1A};
        vecs[14] = '{1'b1, 8'h1B, 4'd13, 5'b01001, 1'b1, 8'h1B};
        vecs[15] = '{1'b1, 8'h1C, 4'd14, 5'b01000, 1'b1, 8'h1C};
        vecs[16] = '{1'b1, 8'h1D, 4'd15, 5'b11000, 1'b1, 8'h1D};

        rst_n = 1'b0;
        en    = 1'b0;
        wptr  = 5'b00000;
        mem   = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_empty", 32'(rempty), 32'd1);
        check("rst_valid", 32'(rvalid), 32'd0);
        check("rst_addr",  32'(addr),   32'd0);
        check("rst_gray",  32'(rgray),  32'd0);
        check("rst_data",  32'(rdata),  32'd0);
        check("rst_tmr",   32'(terr),   32'd0);
        rst_n = 1'b1;
        tick();

        // write pointer moves to binary 2; empty must not drop after only one clock
        wptr = 5'b00011;
        tick();
        check("empty_early", 32'(rempty), 32'd1);
        tick();
        tick();
        check("empty_clear", 32'(rempty), 32'd0);
        check("addr_first",  32'(addr),   32'd0);
        en  = 1'b1;
        mem = 8'hA1;
        tick();
        check("data_a1",  32'(rdata),  32'hA1);
        check("valid_a1", 32'(rvalid), 32'd1);
        check("addr_1",   32'(addr),   32'd1);
        mem = 8'hB2;
        tick();
        en = 1'b0;
        check("data_b2",   32'(rdata),  32'hB2);
        check("valid_b2",  32'(rvalid), 32'd1);
        check("empty_set", 32'(rempty), 32'd1);
        check("gray_2",    32'(rgray),  32'b00011);

        // pop request while empty is ignored
        en  = 1'b1;
        mem = 8'hEE;
        tick();
        en = 1'b0;
        check("emptypop_addr",  32'(addr),   32'd2);
        check("emptypop_valid", 32'(rvalid), 32'd0);
        check("emptypop_data",  32'(rdata),  32'hB2);
        check("emptypop_tmr",   32'(terr),   32'd0);

        // run the pointer up through address 15 and wrap to binary 16
        wptr = 5'b11110;
        for (int i = 0; i < 17; i++) begin
            en  = vecs[i].en;
            mem = vecs[i].din;
            check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
            tick();
            check($sformatf("vec%0d_gray", i),  32'(rgray),  32'(vecs[i].exp_gray));
            check($sformatf("vec%0d_valid", i), 32'(rvalid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i),  32'(rdata),  32'(vecs[i].exp_data));
            check($sformatf("vec%0d_tmr", i),   32'(terr),   32'd0);
        end
        en = 1'b0;
        check("wrap_addr",  32'(addr),   32'd0);
        check("wrap_empty", 32'(rempty), 32'd0);
        tick();
        check("wrap_idle_valid", 32'(rvalid), 32'd0);
        check("wrap_idle_gray",  32'(rgray),  32'b11000);

`ifdef READ_PTR_TMR_EN
        force dut.bin1_r = 5'h1F;
        #1;
        release dut.bin1_r;
        check("upset_addr", 32'(addr), 32'd0);
        @(negedge clk);
        check("upset_pulse",  32'(terr), 32'd1);
        check("upset_addr2",  32'(addr), 32'd0);
        check("upset_copies", 32'(dut.bin1_r == dut.bin0_r && dut.bin2_r == dut.bin0_r), 32'd1);
        tick();
        check("upset_clear", 32'(terr), 32'd0);
`else
        tick();
        check("notmr_error", 32'(terr), 32'd0);
`endif

        // reset asserted in the middle of a pop stream
        en  = 1'b1;
        mem = 8'h5A;
        tick();
        check("stream_valid", 32'(rvalid), 32'd1);
        check("stream_data",  32'(rdata),  32'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_empty", 32'(rempty), 32'd1);
        check("midrst_valid", 32'(rvalid), 32'd0);
        check("midrst_data",  32'(rdata),  32'd0);
        check("midrst_gray",  32'(rgray),  32'd0);
        check("midrst_addr",  32'(addr),   32'd0);
        check("midrst_tmr",   32'(terr),   32'd0);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(rvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
